control_fsm: RTL and testbench
==============================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Parameter DATA_W, default 32, instruction/immediate width.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 Parameter PC_W, default 26, jump-target width.
REQ-004 Parameter FLAG_W, default 8, status-register width.
REQ-005 Parameter MEM_TIMEOUT, default 15, maximum memory wait cycles (>=1).
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 instruction  in  DATA_W  fetched instruction word.
REQ-009 instr_valid  in  1  instruction word is valid this cycle.
REQ-010 status_reg  in  FLAG_W  ALU flags; bit 0 = equal.
REQ-011 mem_ready  in  1  data-memory access complete.
REQ-012 fetch_req  out  1  request next instruction.
REQ-013 alu_op  out  4  ALU function: NOP 0, ADD 1, SUB 2, MUL 3, AND 4, OR 5.
REQ-014 alu_src1, alu_src2, alu_dest  out  REG_AW each  register selects.
REQ-015 reg_write_enable, imm, load_pc, mem_rd, mem_wr, mem_data_in  out  1 each  datapath strobes.
REQ-016 imm_val  out  DATA_W; load_pc_val  out  PC_W.
REQ-017 state  out  3  current FSM state encoding; halted  out  1; illegal  out  1; mem_err  out  1.

Function
REQ-018 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; all other codes return to FETCH next cycle.
REQ-019 FETCH: fetch_req=1; on instr_valid, instruction latched into IR and go to DECODE; otherwise remain in FETCH.
REQ-020 DECODE: one cycle; opcode IR[DATA_W-1:DATA_W-6] decoded into registered control fields; go to EXEC.
REQ-021 Opcodes: NOP 0, ADD 1, SUB 2, MUL 3, AND 4, OR 5, JMP 6, LUI 7, LLI 8, CMP 10, JEQ 11, LOD 12, STR 13, HLT 63; all others illegal.
REQ-022 Register fields: rs=IR[25:21], rt=IR[20:16], rd=IR[15:11]; immediate IR[15:0]; target IR[PC_W-1:0].
REQ-023 ADD/SUB/MUL/AND/OR: alu_op, alu_src1=rs, alu_src2=rt, alu_dest=rd driven in EXEC and WB; reg_write_enable=1 in WB only.
REQ-024 LUI: alu_dest=rs, imm=1, imm_val={IR[15:0], zeros}; LLI: alu_op=OR, alu_src2=alu_dest=rs, imm=1, imm_val=zero-extended IR[15:0]; both write in WB.
REQ-025 CMP: alu_op=SUB, src1=rs, src2=rt in EXEC; no writeback; EXEC->FETCH.
REQ-026 JMP: load_pc=1, load_pc_val=target for exactly the EXEC cycle; JEQ identical but load_pc=status_reg[0] sampled in EXEC; EXEC->FETCH.
REQ-027 LOD: EXEC->MEM; mem_rd=1, mem_data_in=1, alu_src1=rt, alu_dest=rs held through MEM; mem_ready -> WB with reg_write_enable=1.
REQ-028 STR: EXEC->MEM; mem_wr=1, alu_src1=rt, alu_src2=rs held through MEM; mem_ready -> FETCH.
REQ-029 Wait counter counts MEM cycles; if MEM_TIMEOUT cycles elapse without mem_ready, abort to FETCH with no writeback and set sticky mem_err.
REQ-030 mem_ready in the same cycle as timeout expiry counts as success.
REQ-031 NOP: EXEC->FETCH, all strobes 0. Illegal opcode: behave as NOP, set sticky illegal.
REQ-032 HLT: EXEC->HALT; HALT is terminal until rst; halted=1; fetch_req and all strobes 0.
REQ-033 Outside the states named above, every strobe and select is 0.
REQ-034 ALU instruction latency: instr_valid at cycle t -> reg_write_enable at t+3, fetch_req again at t+4.

Reset
REQ-035 rst asserted at any time, including mid-MEM, forces state=FETCH, IR=0, wait counter=0, illegal=mem_err=halted=0 and all outputs 0 except fetch_req=1 once rst deasserts.
REQ-036 No memory strobe shall remain asserted in the cycle after rst asserts.

Structure
REQ-037 Opcode, ALU-function and state localparams live in shared package cpu_pkg.
REQ-038 One sub-module, instr_decoder (combinational opcode-to-control-field table), instantiated once; control_fsm registers its outputs.

Verification
REQ-039 ADD 0x04432000 with instr_valid at t -> alu_op=1, src1=2, src2=3, dest=4; reg_write_enable=1 only at t+3.
REQ-040 JEQ 0x2C000100, status_reg[0]=1 -> load_pc=1, load_pc_val=0x100 for one cycle; repeat with bit 0=0 -> load_pc stays 0.
REQ-041 LOD 0x30220000, mem_ready after 3 MEM cycles -> mem_rd=1 for 3 cycles, then WB with dest=1; same with mem_ready never -> abort after 15 cycles, mem_err=1.
REQ-042 LUI 0x1CA0ABCD -> imm=1, imm_val=0xABCD0000, dest=5, write in WB.
REQ-043 HLT 0xFC000000 -> halted=1, fetch_req=0 indefinitely; rst releases to FETCH.
REQ-044 Opcode 0x3E, then rst asserted during STR MEM wait -> illegal=1, then all outputs cleared asynchronously, mem_wr=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the control FSM: state codes, instruction opcodes
// and ALU function selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_NOP = 6'd0;
  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;
  localparam logic [5:0] OP_MUL = 6'd3;
  localparam logic [5:0] OP_AND = 6'd4;
  localparam logic [5:0] OP_OR  = 6'd5;
  localparam logic [5:0] OP_JMP = 6'd6;
  localparam logic [5:0] OP_LUI = 6'd7;
  localparam logic [5:0] OP_LLI = 6'd8;
  localparam logic [5:0] OP_CMP = 6'd10;
  localparam logic [5:0] OP_JEQ = 6'd11;
  localparam logic [5:0] OP_LOD = 6'd12;
  localparam logic [5:0] OP_STR = 6'd13;
  localparam logic [5:0] OP_HLT = 6'd63;

  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_MUL = 4'd3;
  localparam logic [3:0] ALU_AND = 4'd4;
  localparam logic [3:0] ALU_OR  = 4'd5;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode-to-control-field table. Register selects are already
// resolved per instruction class so the FSM only has to time them.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int PC_W   = 26
) (
  input  logic [DATA_W-1:0] instruction,
  output logic [3:0]        alu_op,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic [REG_AW-1:0] dest,
  output logic              imm,
  output logic [DATA_W-1:0] imm_val,
  output logic [PC_W-1:0]   target,
  output logic              reg_write,
  output logic              is_jump,
  output logic              is_cond,
  output logic              is_load,
  output logic              is_store,
  output logic              is_halt,
  output logic              illegal
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;

  assign opcode = instruction[DATA_W-1 -: 6];
  assign rs     = instruction[21 +: REG_AW];
  assign rt     = instruction[16 +: REG_AW];
  assign rd     = instruction[11 +: REG_AW];
  assign target = instruction[PC_W-1:0];

  // Opcode lookup; anything not listed is flagged illegal and otherwise acts as NOP.
  always_comb begin
    alu_op    = ALU_NOP;
    src1      = '0;
    src2      = '0;
    dest      = '0;
    imm       = 1'b0;
    imm_val   = '0;
    reg_write = 1'b0;
    is_jump   = 1'b0;
    is_cond   = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_halt   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR: begin
        // The ALU function codes coincide with these opcodes.
        alu_op    = opcode[3:0];
        src1      = rs;
        src2      = rt;
        dest      = rd;
        reg_write = 1'b1;
      end
      OP_LUI: begin
        dest      = rs;
        imm       = 1'b1;
        imm_val   = {instruction[15:0], {(DATA_W-16){1'b0}}};
        reg_write = 1'b1;
      end
      OP_LLI: begin
        alu_op    = ALU_OR;
        src2      = rs;
        dest      = rs;
        imm       = 1'b1;
        imm_val   = {{(DATA_W-16){1'b0}}, instruction[15:0]};
        reg_write = 1'b1;
      end
      OP_CMP: begin
        alu_op = ALU_SUB;
        src1   = rs;
        src2   = rt;
      end
      OP_JMP: is_jump = 1'b1;
      OP_JEQ: begin
        is_jump = 1'b1;
        is_cond = 1'b1;
      end
      OP_LOD: begin
        src1      = rt;
        dest      = rs;
        is_load   = 1'b1;
        reg_write = 1'b1;
      end
      OP_STR: begin
        src1     = rt;
        src2     = rs;
        is_store = 1'b1;
      end
      OP_HLT: is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// Outputs are registered from the next state so each strobe lines up with
// the state it belongs to; only the JEQ condition is applied live in EXEC.
module control_fsm
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int PC_W        = 26,
  parameter int FLAG_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instruction,
  input  logic              instr_valid,
  input  logic [FLAG_W-1:0] status_reg,
  input  logic              mem_ready,
  output logic              fetch_req,
  output logic [3:0]        alu_op,
  output logic [REG_AW-1:0] alu_src1,
  output logic [REG_AW-1:0] alu_src2,
  output logic [REG_AW-1:0] alu_dest,
  output logic              reg_write_enable,
  output logic              imm,
  output logic              load_pc,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              mem_data_in,
  output logic [DATA_W-1:0] imm_val,
  output logic [PC_W-1:0]   load_pc_val,
  output logic [2:0]        state,
  output logic              halted,
  output logic              illegal,
  output logic              mem_err
);

  // Counter holds 0..MEM_TIMEOUT-1; the last value is the final allowed MEM cycle.
  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] ir_reg;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              mem_timeout;
  logic              illegal_reg, mem_err_reg;

  // Decoder outputs and their registered copies captured in DECODE.
  logic [3:0]        dec_alu_op, ctl_alu_op_reg, sel_alu_op;
  logic [REG_AW-1:0] dec_src1, ctl_src1_reg, sel_src1;
  logic [REG_AW-1:0] dec_src2, ctl_src2_reg, sel_src2;
  logic [REG_AW-1:0] dec_dest, ctl_dest_reg, sel_dest;
  logic              dec_imm, ctl_imm_reg, sel_imm;
  logic [DATA_W-1:0] dec_imm_val, ctl_imm_val_reg, sel_imm_val;
  logic [PC_W-1:0]   dec_target, ctl_target_reg, sel_target;
  logic              dec_reg_write, ctl_reg_write_reg;
  logic              dec_is_jump, ctl_is_jump_reg, sel_is_jump;
  logic              dec_is_cond, ctl_is_cond_reg;
  logic              dec_is_load, ctl_is_load_reg, sel_is_load;
  logic              dec_is_store, ctl_is_store_reg, sel_is_store;
  logic              dec_is_halt, ctl_is_halt_reg;
  logic              dec_illegal;
  logic              use_dec;

  // Registered output copies.
  logic              fetch_req_reg, fetch_req_next;
  logic [3:0]        alu_op_reg, alu_op_next;
  logic [REG_AW-1:0] alu_src1_reg, alu_src1_next;
  logic [REG_AW-1:0] alu_src2_reg, alu_src2_next;
  logic [REG_AW-1:0] alu_dest_reg, alu_dest_next;
  logic              rwe_reg, rwe_next;
  logic              imm_reg, imm_next;
  logic [DATA_W-1:0] imm_val_reg, imm_val_next;
  logic              load_pc_arm_reg, load_pc_arm_next;
  logic [PC_W-1:0]   load_pc_val_reg, load_pc_val_next;
  logic              mem_rd_reg, mem_rd_next;
  logic              mem_wr_reg, mem_wr_next;
  logic              mem_data_in_reg, mem_data_in_next;
  logic              halted_reg, halted_next;

  logic              unused_flags;
  assign unused_flags = ^status_reg[FLAG_W-1:1];

  instr_decoder #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .PC_W   (PC_W)
  ) u_decoder (
    .instruction (ir_reg),
    .alu_op      (dec_alu_op),
    .src1        (dec_src1),
    .src2        (dec_src2),
    .dest        (dec_dest),
    .imm         (dec_imm),
    .imm_val     (dec_imm_val),
    .target      (dec_target),
    .reg_write   (dec_reg_write),
    .is_jump     (dec_is_jump),
    .is_cond     (dec_is_cond),
    .is_load     (dec_is_load),
    .is_store    (dec_is_store),
    .is_halt     (dec_is_halt),
    .illegal     (dec_illegal)
  );

  // While decoding, the control fields are not registered yet, so outputs
  // for the upcoming EXEC cycle come straight from the decoder.
  assign use_dec      = (state_reg == ST_DECODE);
  assign sel_alu_op   = use_dec ? dec_alu_op   : ctl_alu_op_reg;
  assign sel_src1     = use_dec ? dec_src1     : ctl_src1_reg;
  assign sel_src2     = use_dec ? dec_src2     : ctl_src2_reg;
  assign sel_dest     = use_dec ? dec_dest     : ctl_dest_reg;
  assign sel_imm      = use_dec ? dec_imm      : ctl_imm_reg;
  assign sel_imm_val  = use_dec ? dec_imm_val  : ctl_imm_val_reg;
  assign sel_target   = use_dec ? dec_target   : ctl_target_reg;
  assign sel_is_jump  = use_dec ? dec_is_jump  : ctl_is_jump_reg;
  assign sel_is_load  = use_dec ? dec_is_load  : ctl_is_load_reg;
  assign sel_is_store = use_dec ? dec_is_store : ctl_is_store_reg;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_FETCH;
    else     state_reg <= state_next;
  end

  // Next-state, memory wait counting and next-cycle output values.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    mem_timeout   = 1'b0;
    case (state_reg)
      ST_FETCH:  if (instr_valid) state_next = ST_DECODE;
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC: begin
        if (ctl_is_halt_reg)                        state_next = ST_HALT;
        else if (ctl_is_load_reg || ctl_is_store_reg) state_next = ST_MEM;
        else if (ctl_reg_write_reg)                 state_next = ST_WB;
        else                                        state_next = ST_FETCH;
      end
      ST_MEM: begin
        // A ready arriving on the last allowed cycle still wins over the timeout.
        if (mem_ready) begin
          state_next = ctl_is_load_reg ? ST_WB : ST_FETCH;
        end else if (wait_cnt_reg == CNT_LAST) begin
          state_next  = ST_FETCH;
          mem_timeout = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      ST_WB:   state_next = ST_FETCH;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_FETCH;
    endcase

    fetch_req_next   = 1'b0;
    alu_op_next      = ALU_NOP;
    alu_src1_next    = '0;
    alu_src2_next    = '0;
    alu_dest_next    = '0;
    rwe_next         = 1'b0;
    imm_next         = 1'b0;
    imm_val_next     = '0;
    load_pc_arm_next = 1'b0;
    load_pc_val_next = '0;
    mem_rd_next      = 1'b0;
    mem_wr_next      = 1'b0;
    mem_data_in_next = 1'b0;
    halted_next      = 1'b0;
    case (state_next)
      ST_FETCH: fetch_req_next = 1'b1;
      ST_EXEC, ST_MEM, ST_WB: begin
        alu_op_next   = sel_alu_op;
        alu_src1_next = sel_src1;
        alu_src2_next = sel_src2;
        alu_dest_next = sel_dest;
        imm_next      = sel_imm;
        imm_val_next  = sel_imm_val;
        if (state_next == ST_EXEC && sel_is_jump) begin
          load_pc_arm_next = 1'b1;
          load_pc_val_next = sel_target;
        end
        if (state_next == ST_MEM) begin
          mem_rd_next      = sel_is_load;
          mem_data_in_next = sel_is_load;
          mem_wr_next      = sel_is_store;
        end
        if (state_next == ST_WB) rwe_next = 1'b1;
      end
      ST_HALT: halted_next = 1'b1;
      default: ;
    endcase
  end

  // IR, control fields, wait counter, sticky flags and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir_reg            <= '0;
      ctl_alu_op_reg    <= ALU_NOP;
      ctl_src1_reg      <= '0;
      ctl_src2_reg      <= '0;
      ctl_dest_reg      <= '0;
      ctl_imm_reg       <= 1'b0;
      ctl_imm_val_reg   <= '0;
      ctl_target_reg    <= '0;
      ctl_reg_write_reg <= 1'b0;
      ctl_is_jump_reg   <= 1'b0;
      ctl_is_cond_reg   <= 1'b0;
      ctl_is_load_reg   <= 1'b0;
      ctl_is_store_reg  <= 1'b0;
      ctl_is_halt_reg   <= 1'b0;
      wait_cnt_reg      <= '0;
      illegal_reg       <= 1'b0;
      mem_err_reg       <= 1'b0;
      fetch_req_reg     <= 1'b1;
      alu_op_reg        <= ALU_NOP;
      alu_src1_reg      <= '0;
      alu_src2_reg      <= '0;
      alu_dest_reg      <= '0;
      rwe_reg           <= 1'b0;
      imm_reg           <= 1'b0;
      imm_val_reg       <= '0;
      load_pc_arm_reg   <= 1'b0;
      load_pc_val_reg   <= '0;
      mem_rd_reg        <= 1'b0;
      mem_wr_reg        <= 1'b0;
      mem_data_in_reg   <= 1'b0;
      halted_reg        <= 1'b0;
    end else begin
      if (state_reg == ST_FETCH && instr_valid) ir_reg <= instruction;
      if (use_dec) begin
        ctl_alu_op_reg    <= dec_alu_op;
        ctl_src1_reg      <= dec_src1;
        ctl_src2_reg      <= dec_src2;
        ctl_dest_reg      <= dec_dest;
        ctl_imm_reg       <= dec_imm;
        ctl_imm_val_reg   <= dec_imm_val;
        ctl_target_reg    <= dec_target;
        ctl_reg_write_reg <= dec_reg_write;
        ctl_is_jump_reg   <= dec_is_jump;
        ctl_is_cond_reg   <= dec_is_cond;
        ctl_is_load_reg   <= dec_is_load;
        ctl_is_store_reg  <= dec_is_store;
        ctl_is_halt_reg   <= dec_is_halt;
        if (dec_illegal) illegal_reg <= 1'b1;
      end
      wait_cnt_reg <= wait_cnt_next;
      if (mem_timeout) mem_err_reg <= 1'b1;
      fetch_req_reg   <= fetch_req_next;
      alu_op_reg      <= alu_op_next;
      alu_src1_reg    <= alu_src1_next;
      alu_src2_reg    <= alu_src2_next;
      alu_dest_reg    <= alu_dest_next;
      rwe_reg         <= rwe_next;
      imm_reg         <= imm_next;
      imm_val_reg     <= imm_val_next;
      load_pc_arm_reg <= load_pc_arm_next;
      load_pc_val_reg <= load_pc_val_next;
      mem_rd_reg      <= mem_rd_next;
      mem_wr_reg      <= mem_wr_next;
      mem_data_in_reg <= mem_data_in_next;
      halted_reg      <= halted_next;
    end
  end

  assign fetch_req        = fetch_req_reg;
  assign alu_op           = alu_op_reg;
  assign alu_src1         = alu_src1_reg;
  assign alu_src2         = alu_src2_reg;
  assign alu_dest         = alu_dest_reg;
  assign reg_write_enable = rwe_reg;
  assign imm              = imm_reg;
  assign imm_val          = imm_val_reg;
  // JEQ looks at the equal flag as it stands during EXEC itself.
  assign load_pc          = load_pc_arm_reg & (~ctl_is_cond_reg | status_reg[0]);
  assign load_pc_val      = load_pc_val_reg;
  assign mem_rd           = mem_rd_reg;
  assign mem_wr           = mem_wr_reg;
  assign mem_data_in      = mem_data_in_reg;
  assign state            = state_reg;
  assign halted           = halted_reg;
  assign illegal          = illegal_reg;
  assign mem_err          = mem_err_reg;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: each instruction class is issued once and
// its strobes are compared cycle by cycle against hand-derived values.
module tb_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instruction = '0;
  logic        instr_valid = 1'b0;
  logic [7:0]  status_reg = '0;
  logic        mem_ready = 1'b0;
  logic        fetch_req, reg_write_enable, imm, load_pc, mem_rd, mem_wr, mem_data_in;
  logic [3:0]  alu_op;
  logic [4:0]  alu_src1, alu_src2, alu_dest;
  logic [31:0] imm_val;
  logic [25:0] load_pc_val;
  logic [2:0]  state;
  logic        halted, illegal, mem_err;

  int n_checks = 0;
  int n_fail   = 0;

  control_fsm dut (
    .clk              (clk),
    .rst              (rst),
    .instruction      (instruction),
    .instr_valid      (instr_valid),
    .status_reg       (status_reg),
    .mem_ready        (mem_ready),
    .fetch_req        (fetch_req),
    .alu_op           (alu_op),
    .alu_src1         (alu_src1),
    .alu_src2         (alu_src2),
    .alu_dest         (alu_dest),
    .reg_write_enable (reg_write_enable),
    .imm              (imm),
    .load_pc          (load_pc),
    .mem_rd           (mem_rd),
    .mem_wr           (mem_wr),
    .mem_data_in      (mem_data_in),
    .imm_val          (imm_val),
    .load_pc_val      (load_pc_val),
    .state            (state),
    .halted           (halted),
    .illegal          (illegal),
    .mem_err          (mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in FETCH; returns one cycle later in DECODE.
  task automatic issue(input logic [31:0] word, input string name);
    $display("txn %s instr=0x%08h t=%0t", name, word, $time);
    chk({name, "_fetch_req"}, fetch_req, 1);
    chk({name, "_fetch_state"}, state, 0);
    instruction = word;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_mem;
    int n_rd;

    // Reset state.
    repeat (3) step();
    chk("rst_state", state, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_rwe", reg_write_enable, 0);
    chk("rst_halted", halted, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_mem_err", mem_err, 0);
    rst = 1'b0;
    step();
    chk("post_rst_fetch_req", fetch_req, 1);

    // ADD: write strobe exactly at t+3, fetch again at t+4.
    issue(32'h0443_2000, "add");
    chk("add_dec_state", state, 1);
    chk("add_dec_fetch_req", fetch_req, 0);
    chk("add_dec_rwe", reg_write_enable, 0);
    step();
    chk("add_exec_state", state, 2);
    chk("add_exec_alu_op", alu_op, 1);
    chk("add_exec_src1", alu_src1, 2);
    chk("add_exec_src2", alu_src2, 3);
    chk("add_exec_dest", alu_dest, 4);
    chk("add_exec_rwe", reg_write_enable, 0);
    step();
    chk("add_wb_state", state, 4);
    chk("add_wb_rwe", reg_write_enable, 1);
    chk("add_wb_dest", alu_dest, 4);
    chk("add_wb_fetch_req", fetch_req, 0);
    step();
    chk("add_t4_fetch_req", fetch_req, 1);
    chk("add_t4_rwe", reg_write_enable, 0);
    chk("add_t4_alu_op", alu_op, 0);
    chk("add_illegal", illegal, 0);

    // LUI r5, 0xABCD.
    issue(32'h1CA0_ABCD, "lui");
    step();
    chk("lui_exec_imm", imm, 1);
    chk("lui_exec_imm_val", imm_val, 32'hABCD_0000);
    chk("lui_exec_dest", alu_dest, 5);
    chk("lui_exec_rwe", reg_write_enable, 0);
    step();
    chk("lui_wb_rwe", reg_write_enable, 1);
    chk("lui_wb_dest", alu_dest, 5);
    step();

    // LLI r5, 0x1234.
    issue(32'h20A0_1234, "lli");
    step();
    chk("lli_exec_alu_op", alu_op, 5);
    chk("lli_exec_src2", alu_src2, 5);
    chk("lli_exec_dest", alu_dest, 5);
    chk("lli_exec_imm_val", imm_val, 32'h0000_1234);
    step();
    chk("lli_wb_rwe", reg_write_enable, 1);
    step();

    // CMP r2, r3: subtract without writeback.
    issue(32'h2843_2000, "cmp");
    step();
    chk("cmp_exec_alu_op", alu_op, 2);
    chk("cmp_exec_src1", alu_src1, 2);
    chk("cmp_exec_src2", alu_src2, 3);
    step();
    chk("cmp_next_state", state, 0);
    chk("cmp_next_rwe", reg_write_enable, 0);

    // JMP 0x200.
    issue(32'h1800_0200, "jmp");
    step();
    chk("jmp_exec_load_pc", load_pc, 1);
    chk("jmp_exec_val", load_pc_val, 26'h200);
    step();
    chk("jmp_next_load_pc", load_pc, 0);
    chk("jmp_next_state", state, 0);

    // JEQ taken then not taken.
    status_reg = 8'h01;
    issue(32'h2C00_0100, "jeq_taken");
    step();
    chk("jeq1_exec_load_pc", load_pc, 1);
    chk("jeq1_exec_val", load_pc_val, 26'h100);
    step();
    chk("jeq1_next_load_pc", load_pc, 0);
    status_reg = 8'hFE;
    issue(32'h2C00_0100, "jeq_not_taken");
    step();
    chk("jeq0_exec_state", state, 2);
    chk("jeq0_exec_load_pc", load_pc, 0);
    step();
    chk("jeq0_next_state", state, 0);
    status_reg = 8'h00;

    // LOD r1 <- [r2], ready on the third MEM cycle.
    issue(32'h3022_0000, "lod_ready3");
    step();
    chk("lod_exec_mem_rd", mem_rd, 0);
    step();
    chk("lod_mem_src1", alu_src1, 2);
    chk("lod_mem_dest", alu_dest, 1);
    chk("lod_mem_data_in", mem_data_in, 1);
    for (int i = 0; i < 3; i++) begin
      chk("lod_mem_state", state, 3);
      chk("lod_mem_rd", mem_rd, 1);
      if (i == 2) mem_ready = 1'b1;
      step();
    end
    mem_ready = 1'b0;
    chk("lod_wb_state", state, 4);
    chk("lod_wb_rwe", reg_write_enable, 1);
    chk("lod_wb_dest", alu_dest, 1);
    chk("lod_wb_mem_rd", mem_rd, 0);
    step();

    // Ready arriving on the final allowed cycle is still a success.
    issue(32'h3022_0000, "lod_ready15");
    step();
    step();
    for (int i = 0; i < 15; i++) begin
      chk("lod15_mem_state", state, 3);
      if (i == 14) mem_ready = 1'b1;
      step();
    end
    mem_ready = 1'b0;
    chk("lod15_wb_state", state, 4);
    chk("lod15_wb_rwe", reg_write_enable, 1);
    chk("lod15_mem_err", mem_err, 0);
    step();

    // Memory never answers: abort after 15 MEM cycles.
    issue(32'h3022_0000, "lod_timeout");
    step();
    step();
    n_mem = 0;
    n_rd = 0;
    while (state == 3'd3 && n_mem < 40) begin
      n_mem++;
      if (mem_rd) n_rd++;
      step();
    end
    chk("lodto_mem_cycles", n_mem, 15);
    chk("lodto_mem_rd_cycles", n_rd, 15);
    chk("lodto_state", state, 0);
    chk("lodto_mem_err", mem_err, 1);
    chk("lodto_rwe", reg_write_enable, 0);
    chk("lodto_mem_rd", mem_rd, 0);

    // Illegal opcode 0x3E.
    issue(32'hF800_0000, "illegal");
    chk("ill_dec_illegal", illegal, 0);
    step();
    chk("ill_exec_illegal", illegal, 1);
    chk("ill_exec_alu_op", alu_op, 0);
    step();
    chk("ill_next_state", state, 0);
    chk("ill_sticky", illegal, 1);

    // STR, then reset in the middle of the MEM wait.
    issue(32'h3422_0000, "str_rst");
    step();
    step();
    chk("str_mem_wr", mem_wr, 1);
    chk("str_mem_src1", alu_src1, 2);
    chk("str_mem_src2", alu_src2, 1);
    step();
    chk("str_mem2_wr", mem_wr, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("str_rst_async_mem_wr", mem_wr, 0);
    chk("str_rst_async_state", state, 0);
    chk("str_rst_illegal", illegal, 0);
    chk("str_rst_mem_err", mem_err, 0);
    step();
    chk("str_rst_next_mem_wr", mem_wr, 0);
    rst = 1'b0;
    step();
    chk("str_rel_fetch_req", fetch_req, 1);
    chk("str_rel_state", state, 0);

    // HLT: terminal until reset.
    issue(32'hFC00_0000, "hlt");
    step();
    step();
    instruction = 32'h0443_2000;
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hlt_halted", halted, 1);
      chk("hlt_fetch_req", fetch_req, 0);
      chk("hlt_state", state, 5);
      step();
    end
    instr_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("hlt_rst_halted", halted, 0);
    chk("hlt_rst_state", state, 0);
    step();
    rst = 1'b0;
    step();
    chk("hlt_rel_fetch_req", fetch_req, 1);
    chk("hlt_rel_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
